// File: rtl/switch_debouncer_pkg.sv
// rtl/switch_debouncer_pkg.sv - shared constants and counter-width helper for the switch debouncer
package switch_debouncer_pkg;

  localparam int DEBOUNCE_CYCLES_50MHZ_10MS = 500000;
  localparam int DEBOUNCE_CYCLES_SIM        = 4;

  // Counter only ever holds 0..cycles-1, so clog2(cycles) bits suffice; floor at 1 bit.
  function automatic int cnt_width(input int cycles);
    int w;
    w = $clog2(cycles);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/switch_debouncer_debounce_bit.sv
// rtl/switch_debouncer_debounce_bit.sv - one switch bit: 2-flop synchroniser, hold-time counter, stable level and edge pulses
module debounce_bit
  import switch_debouncer_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ_10MS
) (
  input  logic clk,
  input  logic reset_n,
  input  logic sw_raw,
  output logic sw_stable,
  output logic rise_pulse,
  output logic fall_pulse
);

  localparam int              CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic             stable_q, stable_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  always_comb begin
    sync1_d  = sw_raw;
    sync2_d  = sync1_q;
    stable_d = stable_q;
    cnt_d    = '0;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    // Any cycle where sync2 agrees with the stable level discards accumulated credit.
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_MAX) begin
        stable_d = sync2_q;
        rise_d   = sync2_q;
        fall_d   = ~sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      stable_q <= 1'b0;
      cnt_q    <= '0;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync1_q  <= sync1_d;
      sync2_q  <= sync2_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign sw_stable  = stable_q;
  assign rise_pulse = rise_q;
  assign fall_pulse = fall_q;

endmodule

// File: rtl/switch_debouncer.sv
// rtl/switch_debouncer.sv - debounces WIDTH slide switches for the PIO in_port and flags accepted edges
module switch_debouncer
  import switch_debouncer_pkg::*;
#(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ_10MS
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             change_any
);

  logic change_any_q, change_any_d;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_bit (
      .clk       (clk),
      .reset_n   (reset_n),
      .sw_raw    (sw_raw[i]),
      .sw_stable (sw_stable[i]),
      .rise_pulse(rise_pulse[i]),
      .fall_pulse(fall_pulse[i])
    );
  end

  always_comb begin
    change_any_d = |(rise_pulse | fall_pulse);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) change_any_q <= 1'b0;
    else          change_any_q <= change_any_d;
  end

  assign change_any = change_any_q;

endmodule

// File: tb/tb_switch_debouncer.sv
// tb/tb_switch_debouncer.sv - directed self-checking bench for switch_debouncer with a 4-cycle hold time
module tb_switch_debouncer;
  import switch_debouncer_pkg::*;

  localparam int W = 10;
  localparam int D = DEBOUNCE_CYCLES_SIM;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [W-1:0] sw_raw;
  logic [W-1:0] sw_stable;
  logic [W-1:0] rise_pulse;
  logic [W-1:0] fall_pulse;
  logic         change_any;

  int tests = 0;
  int fails = 0;

  switch_debouncer #(
    .WIDTH(W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .sw_raw    (sw_raw),
    .sw_stable (sw_stable),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .change_any(change_any)
  );

  always #5 clk = ~clk;

  // Advance one edge; inputs and checks both happen 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle(input logic [W-1:0] v);
    sw_raw = v;
    repeat (12) tick();
  endtask

  task automatic test_reset();
    logic [W-1:0] exp_st, exp_r;
    logic         exp_c;
    reset_n = 1'b0;
    sw_raw  = 10'h3FF;
    for (int k = 0; k < 3; k++) begin
      tick();
      tests++;
      if (sw_stable !== 10'h000 || rise_pulse !== 10'h000 || fall_pulse !== 10'h000 || change_any !== 1'b0) begin
        $display("FAIL reset_hold k=%0d stable=%h rise=%h fall=%h chg=%b required all zero",
                 k, sw_stable, rise_pulse, fall_pulse, change_any);
        fails++;
      end
    end
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_st = (k >= 6) ? 10'h3FF : 10'h000;
      exp_r  = (k == 6) ? 10'h3FF : 10'h000;
      exp_c  = (k == 7);
      tests++;
      if (sw_stable !== exp_st) begin
        $display("FAIL reset_release_stable k=%0d got %h want %h", k, sw_stable, exp_st);
        fails++;
      end
      tests++;
      if (rise_pulse !== exp_r) begin
        $display("FAIL reset_release_rise k=%0d got %h want %h", k, rise_pulse, exp_r);
        fails++;
      end
      tests++;
      if (change_any !== exp_c) begin
        $display("FAIL reset_release_change k=%0d got %b want %b", k, change_any, exp_c);
        fails++;
      end
    end
  endtask

  task automatic test_bit0_rise();
    logic [W-1:0] exp_st, exp_r;
    settle(10'h000);
    sw_raw = 10'h001;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_st = (k >= 6) ? 10'h001 : 10'h000;
      exp_r  = (k == 6) ? 10'h001 : 10'h000;
      tests++;
      if (sw_stable !== exp_st) begin
        $display("FAIL bit0_stable k=%0d got %h want %h", k, sw_stable, exp_st);
        fails++;
      end
      tests++;
      if (rise_pulse !== exp_r || fall_pulse !== 10'h000) begin
        $display("FAIL bit0_pulses k=%0d rise=%h fall=%h want rise=%h fall=000", k, rise_pulse, fall_pulse, exp_r);
        fails++;
      end
      tests++;
      if (change_any !== (k == 7)) begin
        $display("FAIL bit0_change k=%0d got %b want %b", k, change_any, (k == 7));
        fails++;
      end
    end
  endtask

  task automatic test_bounce_short();
    sw_raw = 10'h009;
    repeat (3) tick();
    sw_raw = 10'h001;
    for (int k = 4; k <= 12; k++) begin
      tick();
      tests++;
      if (sw_stable !== 10'h001 || rise_pulse !== 10'h000 || fall_pulse !== 10'h000 || change_any !== 1'b0) begin
        $display("FAIL bounce3 k=%0d stable=%h rise=%h fall=%h chg=%b want stable=001 no pulses",
                 k, sw_stable, rise_pulse, fall_pulse, change_any);
        fails++;
      end
    end
    tests++;
    if (dut.g_bit[3].u_bit.cnt_q !== '0) begin
      $display("FAIL bounce3_cnt got %0d want 0", dut.g_bit[3].u_bit.cnt_q);
      fails++;
    end
  endtask

  task automatic test_bounce_multi();
    logic [W-1:0] seq [5];
    logic [W-1:0] exp_st, exp_r;
    int           rises;
    seq[0] = 10'h021; seq[1] = 10'h001; seq[2] = 10'h021; seq[3] = 10'h001; seq[4] = 10'h021;
    rises = 0;
    for (int k = 1; k <= 14; k++) begin
      sw_raw = (k <= 5) ? seq[k-1] : 10'h021;
      tick();
      exp_st = (k >= 10) ? 10'h021 : 10'h001;
      exp_r  = (k == 10) ? 10'h020 : 10'h000;
      if (rise_pulse[5]) rises++;
      tests++;
      if (sw_stable !== exp_st) begin
        $display("FAIL bounce5_stable k=%0d got %h want %h", k, sw_stable, exp_st);
        fails++;
      end
      tests++;
      if (rise_pulse !== exp_r || fall_pulse !== 10'h000) begin
        $display("FAIL bounce5_pulses k=%0d rise=%h fall=%h want rise=%h fall=000", k, rise_pulse, fall_pulse, exp_r);
        fails++;
      end
    end
    tests++;
    if (rises !== 1) begin
      $display("FAIL bounce5_count got %0d rises want 1", rises);
      fails++;
    end
  endtask

  task automatic test_simul_fall();
    logic [W-1:0] exp_st, exp_f;
    settle(10'h0A5);
    tests++;
    if (sw_stable !== 10'h0A5) begin
      $display("FAIL simul_setup got %h want 0a5", sw_stable);
      fails++;
    end
    sw_raw = 10'h021;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_st = (k >= 6) ? 10'h021 : 10'h0A5;
      exp_f  = (k == 6) ? 10'h084 : 10'h000;
      tests++;
      if (sw_stable !== exp_st) begin
        $display("FAIL simul_stable k=%0d got %h want %h", k, sw_stable, exp_st);
        fails++;
      end
      tests++;
      if (fall_pulse !== exp_f || rise_pulse !== 10'h000) begin
        $display("FAIL simul_pulses k=%0d fall=%h rise=%h want fall=%h rise=000", k, fall_pulse, rise_pulse, exp_f);
        fails++;
      end
      tests++;
      if (change_any !== (k == 7)) begin
        $display("FAIL simul_change k=%0d got %b want %b", k, change_any, (k == 7));
        fails++;
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [W-1:0] exp_st, exp_r;
    sw_raw = 10'h221;
    repeat (4) tick();
    tests++;
    if (dut.g_bit[9].u_bit.cnt_q !== 2) begin
      $display("FAIL midcnt_setup cnt got %0d want 2", dut.g_bit[9].u_bit.cnt_q);
      fails++;
    end
    #2;
    reset_n = 1'b0;
    #1;
    tests++;
    if (sw_stable !== 10'h000 || rise_pulse !== 10'h000 || fall_pulse !== 10'h000 || change_any !== 1'b0) begin
      $display("FAIL midcnt_async stable=%h rise=%h fall=%h chg=%b required all zero",
               sw_stable, rise_pulse, fall_pulse, change_any);
      fails++;
    end
    repeat (2) tick();
    reset_n = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      exp_st = (k >= 6) ? 10'h221 : 10'h000;
      exp_r  = (k == 6) ? 10'h221 : 10'h000;
      tests++;
      if (sw_stable !== exp_st) begin
        $display("FAIL midcnt_stable k=%0d got %h want %h", k, sw_stable, exp_st);
        fails++;
      end
      tests++;
      if (rise_pulse !== exp_r) begin
        $display("FAIL midcnt_rise k=%0d got %h want %h", k, rise_pulse, exp_r);
        fails++;
      end
      tests++;
      if (change_any !== (k == 7)) begin
        $display("FAIL midcnt_change k=%0d got %b want %b", k, change_any, (k == 7));
        fails++;
      end
    end
  endtask

  initial begin
    reset_n = 1'b0;
    sw_raw  = '0;
    test_reset();
    test_bit0_rise();
    test_bounce_short();
    test_bounce_multi();
    test_simul_fall();
    test_reset_mid_count();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
